// File: rtl/definitions.sv
// Shared definitions for the 8-bit ALU datapath and its multi-precision sequencer.
package definitions;

  localparam int ALU_BYTE_W = 8;

  typedef enum logic [2:0] {
    SLL = 3'd0,
    SRL = 3'd1,
    LSW = 3'd2,
    CLR = 3'd3,
    EMK = 3'd4,
    INC = 3'd5,
    ADD = 3'd6,
    SUB = 3'd7
  } op_code;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/alu_mp_seq.sv
// Multi-precision sequencer: feeds one byte per cycle through the 8-bit ALU,
// chains the ov bit between bytes and assembles the wide result.
module alu_mp_seq
  import definitions::*;
#(
  parameter int NBYTES = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start_i,
  input  logic [2:0]                   op_i,
  input  logic [ALU_BYTE_W*NBYTES-1:0] a_i,
  input  logic [ALU_BYTE_W*NBYTES-1:0] b_i,
  input  logic                         cin_i,
  output logic                         ready_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [ALU_BYTE_W*NBYTES-1:0] result_o,
  output logic                         cout_o,
  output logic [ALU_BYTE_W-1:0]        alu_rs_o,
  output logic [ALU_BYTE_W-1:0]        alu_rt_o,
  output logic [2:0]                   alu_op_o,
  output logic                         alu_ov_o,
  input  logic [ALU_BYTE_W-1:0]        alu_result_i,
  input  logic                         alu_ov_i
);

  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  seq_state_t state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] idx;
  logic          ov_q;
  logic          cout_q;
  logic          done_q;
  logic          busy_q;
  logic          ready_q;
  op_code        op_q;

  logic [NBYTES-1:0][ALU_BYTE_W-1:0] a_q;
  logic [NBYTES-1:0][ALU_BYTE_W-1:0] b_q;
  logic [NBYTES-1:0][ALU_BYTE_W-1:0] res_q;

  logic accept;
  assign accept = start_i && (state != RUN);

  // Right shifts must see the upper byte first so its low bit flows down.
  assign idx = (op_q == SRL) ? (LAST - cnt) : cnt;

  // NOTE: operand latches carry no reset; they are only read in RUN, which is
  // always entered through an accepted start that loads them.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q <= op_code'(op_i);
      a_q  <= a_i;
      b_q  <= b_i;
    end
  end

  // NOTE: every clocked assignment is non-blocking so all registers update
  // from the same pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      ov_q    <= 1'b0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start_i) begin
            ov_q    <= cin_i;
            cnt     <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
            state   <= RUN;
          end else begin
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            state   <= IDLE;
          end
        end
        RUN: begin
          res_q[idx] <= alu_result_i;
          ov_q       <= alu_ov_i;
          if (cnt == LAST) begin
            cnt     <= '0;
            cout_q  <= alu_ov_i;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            state   <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

  // NOTE: every output is given a default first so no path leaves a latch.
  always_comb begin
    alu_op_o = LSW;
    alu_rs_o = '0;
    alu_rt_o = '0;
    alu_ov_o = 1'b0;
    if (state == RUN) begin
      alu_op_o = op_q;
      alu_rs_o = a_q[idx];
      alu_rt_o = b_q[idx];
      alu_ov_o = ov_q;
      // Wide increment: only byte 0 increments, the rest just add the carry.
      if (op_q == INC && cnt != '0) begin
        alu_op_o = ADD;
        alu_rt_o = '0;
      end
    end
  end

  assign ready_o  = ready_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = res_q;
  assign cout_o   = cout_q;

endmodule
